seq_alu: RTL

//  Parametrised multi-cycle ALU for the datapath; keeps the existing 5-bit opcode map.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu. Optional flags[2:0] exists only with SEQ_ALU_FLAGS_EN.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic               start;
  logic [4:0]         opcode;
  logic [WIDTH-1:0]   Ra;
  logic [WIDTH-1:0]   Rb;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] Rc;
  logic               div_zero;
  logic               illegal_op;
`ifdef SEQ_ALU_FLAGS_EN
  logic [2:0]         flags;

  modport master (output start, opcode, Ra, Rb,
                  input  busy, done, Rc, div_zero, illegal_op, flags);
  modport slave  (input  start, opcode, Ra, Rb,
                  output busy, done, Rc, div_zero, illegal_op, flags);
`else
  modport master (output start, opcode, Ra, Rb,
                  input  busy, done, Rc, div_zero, illegal_op);
  modport slave  (input  start, opcode, Ra, Rb,
                  output busy, done, Rc, div_zero, illegal_op);
`endif
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift ops, W-iteration signed mul/div on magnitudes.
// Optional {zero,neg,ovf} result flags are built only when SEQ_ALU_FLAGS_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clock,
  input logic      clear_n,
  seq_alu_if.slave bus
);
  localparam int W   = WIDTH;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                         OP_OR   = 5'b00011, OP_SHR = 5'b00100, OP_SHRA = 5'b00101,
                         OP_SHL  = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000,
                         OP_DIV  = 5'b01100, OP_MUL = 5'b01101, OP_NEG = 5'b01110,
                         OP_NOT  = 5'b01111;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [2*W-1:0]   res_q, res_d, rc_q, rc_d;
  logic             dz_q, dz_d, il_q, il_d, busy_q, busy_d, done_q, done_d;
  logic             dzo_q, dzo_d, ilo_q, ilo_d;

  logic [W-1:0]     alu_s;
  logic             alu_ill_s;
  logic [SHW-1:0]   sh_s;
  logic [2*W-1:0]   rot_r_s, rot_l_s, prod_s, fix_s;
  logic [W:0]       mul_sum_s, div_sh_s, div_diff_s;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] mag_w(input logic [W-1:0] x);
    return x[W-1] ? neg_w(x) : x;
  endfunction

  assign sh_s       = b_q[SHW-1:0];
  assign rot_r_s    = {a_q, a_q} >> sh_s;
  assign rot_l_s    = {a_q, a_q} << sh_s;
  assign prod_s     = {hi_q, lo_q};
  // hi:lo is the shift-add product for Mul and remainder:quotient for Div
  assign mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
  assign div_sh_s   = {hi_q, lo_q[W-1]};
  assign div_diff_s = div_sh_s - {1'b0, m_q};

  always_comb begin
    alu_s     = {W{1'b0}};
    alu_ill_s = 1'b0;
    case (op_q)
      OP_ADD:  alu_s = a_q + b_q;
      OP_SUB:  alu_s = a_q - b_q;
      OP_AND:  alu_s = a_q & b_q;
      OP_OR:   alu_s = a_q | b_q;
      OP_SHR:  alu_s = a_q >> sh_s;
      OP_SHRA: alu_s = $signed(a_q) >>> sh_s;
      OP_SHL:  alu_s = a_q << sh_s;
      OP_ROR:  alu_s = rot_r_s[W-1:0];
      OP_ROL:  alu_s = rot_l_s[2*W-1:W];
      OP_NEG:  alu_s = neg_w(b_q);
      OP_NOT:  alu_s = ~b_q;
      default: alu_ill_s = 1'b1;
    endcase
  end

  always_comb begin
    if (op_q == OP_MUL) begin
      fix_s = (a_q[W-1] ^ b_q[W-1]) ? (~prod_s + {{(2*W-1){1'b0}}, 1'b1}) : prod_s;
    end else begin
      fix_s = {(a_q[W-1] ? neg_w(hi_q) : hi_q),
               ((a_q[W-1] ^ b_q[W-1]) ? neg_w(lo_q) : lo_q)};
    end
  end

  always_comb begin
    state_d = state_q; op_d = op_q; a_d = a_q; b_d = b_q;
    hi_d = hi_q; lo_d = lo_q; m_d = m_q; cnt_d = cnt_q; res_d = res_q; rc_d = rc_q;
    dz_d = dz_q; il_d = il_q; busy_d = busy_q; done_d = 1'b0; dzo_d = dzo_q; ilo_d = ilo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.opcode;
          a_d    = bus.Ra;
          b_d    = bus.Rb;
          busy_d = 1'b1;
          cnt_d  = {(SHW+1){1'b0}};
          dz_d   = 1'b0;
          il_d   = 1'b0;
          dzo_d  = 1'b0;
          ilo_d  = 1'b0;
          if (bus.opcode == OP_MUL)      state_d = S_MUL;
          else if (bus.opcode == OP_DIV) state_d = S_DIV;
          else                           state_d = S_EXEC;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_EXEC: begin
        res_d   = {{W{1'b0}}, alu_s};
        il_d    = alu_ill_s;
        state_d = S_DONE;
      end
      S_MUL: begin
        cnt_d = cnt_q + {{SHW{1'b0}}, 1'b1};
        if (cnt_q == {(SHW+1){1'b0}}) begin
          m_d  = mag_w(a_q);
          lo_d = mag_w(b_q);
          hi_d = {W{1'b0}};
        end else begin
          hi_d = mul_sum_s[W:1];
          lo_d = {mul_sum_s[0], lo_q[W-1:1]};
          if (cnt_q == LAST_CNT) state_d = S_FIX;
          else                   state_d = S_MUL;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + {{SHW{1'b0}}, 1'b1};
        if (cnt_q == {(SHW+1){1'b0}}) begin
          m_d  = mag_w(b_q);
          lo_d = mag_w(a_q);
          hi_d = {W{1'b0}};
          if (b_q == {W{1'b0}}) begin
            res_d   = {a_q, {W{1'b1}}};
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          if (!div_diff_s[W]) begin
            hi_d = div_diff_s[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b1};
          end else begin
            hi_d = div_sh_s[W-1:0];
            lo_d = {lo_q[W-2:0], 1'b0};
          end
          if (cnt_q == LAST_CNT) state_d = S_FIX;
          else                   state_d = S_DIV;
        end
      end
      S_FIX: begin
        res_d   = fix_s;
        state_d = S_DONE;
      end
      S_DONE: begin
        rc_d    = res_q;
        dzo_d   = dz_q;
        ilo_d   = il_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE; op_q <= 5'b00000;
      a_q <= {W{1'b0}}; b_q <= {W{1'b0}}; hi_q <= {W{1'b0}}; lo_q <= {W{1'b0}}; m_q <= {W{1'b0}};
      cnt_q <= {(SHW+1){1'b0}}; res_q <= {(2*W){1'b0}}; rc_q <= {(2*W){1'b0}};
      dz_q <= 1'b0; il_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; dzo_q <= 1'b0; ilo_q <= 1'b0;
    end else begin
      state_q <= state_d; op_q <= op_d;
      a_q <= a_d; b_q <= b_d; hi_q <= hi_d; lo_q <= lo_d; m_q <= m_d;
      cnt_q <= cnt_d; res_q <= res_d; rc_q <= rc_d;
      dz_q <= dz_d; il_q <= il_d; busy_q <= busy_d; done_q <= done_d; dzo_q <= dzo_d; ilo_q <= ilo_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.Rc         = rc_q;
  assign bus.div_zero   = dzo_q;
  assign bus.illegal_op = ilo_q;

`ifdef SEQ_ALU_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       ovf_s;

  always_comb begin
    case (op_q)
      OP_ADD:  ovf_s = (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1]);
      OP_SUB:  ovf_s = (a_q[W-1] != b_q[W-1]) && (res_q[W-1] != a_q[W-1]);
      OP_NEG:  ovf_s = (b_q == {1'b1, {(W-1){1'b0}}});
      OP_MUL:  ovf_s = (res_q[2*W-1:W] != {W{res_q[W-1]}});
      default: ovf_s = 1'b0;
    endcase
    if (state_q == S_DONE) begin
      flags_d = {(res_q[W-1:0] == {W{1'b0}}),
                 ((op_q == OP_MUL) ? res_q[2*W-1] : res_q[W-1]),
                 ovf_s};
    end else begin
      flags_d = flags_q;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) flags_q <= 3'b000;
    else          flags_q <= flags_d;
  end

  assign bus.flags = flags_q;
`endif
endmodule
